// File: rtl/tft_spi_monitor.sv
// Passive monitor for a TFT panel SPI link: deserialises bytes from the
// transmitter and decodes CASET/PASET/RAMWR traffic into pixel writes.
module tft_spi_monitor #(
  parameter int X_MAX = 319,
  parameter int Y_MAX = 479
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tft_clk,
  input  logic        tft_mosi,
  input  logic        tft_dc,
  input  logic        tft_cs,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        pixel_valid,
  output logic [8:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic [15:0] pixel_color,
  output logic        in_ramwr
);

  typedef enum logic [1:0] {IDLE, CASET, PASET, RAMWR} state_t;

  localparam logic [8:0] XE_RST = 9'(X_MAX);
  localparam logic [8:0] YE_RST = 9'(Y_MAX);

  logic [1:0]  clk_sync_q, clk_sync_d, mosi_sync_q, mosi_sync_d;
  logic [1:0]  dc_sync_q, dc_sync_d, cs_sync_q, cs_sync_d;
  logic        clk_prev_q, clk_prev_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        done_q, done_d, done_dc_q, done_dc_d;
  logic        byte_valid_q, byte_valid_d, byte_dc_q, byte_dc_d;
  logic [7:0]  byte_data_q, byte_data_d;
  state_t      state_q, state_d;
  logic [1:0]  param_idx_q, param_idx_d;
  logic        hi_flag_q, hi_flag_d;
  logic [7:0]  color_hi_q, color_hi_d;
  logic [8:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [8:0]  x_q, x_d, y_q, y_d;
  logic        pixel_valid_q, pixel_valid_d, in_ramwr_q, in_ramwr_d;
  logic [8:0]  pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic [15:0] pixel_color_q, pixel_color_d;

  always_comb begin
    clk_sync_d    = {clk_sync_q[0], tft_clk};
    mosi_sync_d   = {mosi_sync_q[0], tft_mosi};
    dc_sync_d     = {dc_sync_q[0], tft_dc};
    cs_sync_d     = {cs_sync_q[0], tft_cs};
    clk_prev_d    = clk_sync_q[1];
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    done_d        = 1'b0;
    done_dc_d     = done_dc_q;
    byte_valid_d  = 1'b0;
    byte_data_d   = byte_data_q;
    byte_dc_d     = byte_dc_q;
    state_d       = state_q;
    param_idx_d   = param_idx_q;
    hi_flag_d     = hi_flag_q;
    color_hi_d    = color_hi_q;
    xs_d          = xs_q;
    xe_d          = xe_q;
    ys_d          = ys_q;
    ye_d          = ye_q;
    x_d           = x_q;
    y_d           = y_q;
    pixel_valid_d = 1'b0;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    pixel_color_d = pixel_color_q;

    // Deselect drops any partial byte; a completed byte still goes out via done_q.
    if (cs_sync_q[1]) begin
      bit_cnt_d = 3'd0;
    end else if (clk_sync_q[1] && !clk_prev_q) begin
      shift_d   = {shift_q[6:0], mosi_sync_q[1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        done_d    = 1'b1;
        done_dc_d = dc_sync_q[1];
      end
    end

    if (done_q) begin
      byte_valid_d = 1'b1;
      byte_data_d  = shift_q;
      byte_dc_d    = done_dc_q;
    end

    if (byte_valid_q) begin
      if (!byte_dc_q) begin
        param_idx_d = 2'd0;
        hi_flag_d   = 1'b0;
        case (byte_data_q)
          8'h2A:   state_d = CASET;
          8'h2B:   state_d = PASET;
          8'h2C: begin
            state_d = RAMWR;
            x_d     = xs_q;
            y_d     = ys_q;
          end
          default: state_d = IDLE;
        endcase
      end else begin
        case (state_q)
          CASET, PASET: begin
            param_idx_d = param_idx_q + 2'd1;
            case (param_idx_q)
              2'd0: if (state_q == CASET) xs_d[8] = byte_data_q[0];
                    else ys_d[8] = byte_data_q[0];
              2'd1: if (state_q == CASET) xs_d[7:0] = byte_data_q;
                    else ys_d[7:0] = byte_data_q;
              2'd2: if (state_q == CASET) xe_d[8] = byte_data_q[0];
                    else ye_d[8] = byte_data_q[0];
              default: begin
                if (state_q == CASET) xe_d[7:0] = byte_data_q;
                else ye_d[7:0] = byte_data_q;
                state_d = IDLE;
              end
            endcase
          end
          RAMWR: begin
            if (!hi_flag_q) begin
              color_hi_d = byte_data_q;
              hi_flag_d  = 1'b1;
            end else begin
              hi_flag_d     = 1'b0;
              pixel_valid_d = 1'b1;
              pixel_x_d     = x_q;
              pixel_y_d     = y_q;
              pixel_color_d = {color_hi_q, byte_data_q};
              // Raster scan inside the window, wrapping back to its top-left corner.
              if (x_q >= xe_q) begin
                x_d = xs_q;
                y_d = (y_q >= ye_q) ? ys_q : y_q + 9'd1;
              end else begin
                x_d = x_q + 9'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end

    in_ramwr_d = (state_d == RAMWR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync_q    <= '0;
      mosi_sync_q   <= '0;
      dc_sync_q     <= '0;
      cs_sync_q     <= '0;
      clk_prev_q    <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      done_q        <= 1'b0;
      done_dc_q     <= 1'b0;
      byte_valid_q  <= 1'b0;
      byte_data_q   <= '0;
      byte_dc_q     <= 1'b0;
      state_q       <= IDLE;
      param_idx_q   <= '0;
      hi_flag_q     <= 1'b0;
      color_hi_q    <= '0;
      xs_q          <= '0;
      xe_q          <= XE_RST;
      ys_q          <= '0;
      ye_q          <= YE_RST;
      x_q           <= '0;
      y_q           <= '0;
      pixel_valid_q <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pixel_color_q <= '0;
      in_ramwr_q    <= 1'b0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      dc_sync_q     <= dc_sync_d;
      cs_sync_q     <= cs_sync_d;
      clk_prev_q    <= clk_prev_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      done_q        <= done_d;
      done_dc_q     <= done_dc_d;
      byte_valid_q  <= byte_valid_d;
      byte_data_q   <= byte_data_d;
      byte_dc_q     <= byte_dc_d;
      state_q       <= state_d;
      param_idx_q   <= param_idx_d;
      hi_flag_q     <= hi_flag_d;
      color_hi_q    <= color_hi_d;
      xs_q          <= xs_d;
      xe_q          <= xe_d;
      ys_q          <= ys_d;
      ye_q          <= ye_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      pixel_color_q <= pixel_color_d;
      in_ramwr_q    <= in_ramwr_d;
    end
  end

  assign byte_valid  = byte_valid_q;
  assign byte_data   = byte_data_q;
  assign byte_dc     = byte_dc_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign pixel_color = pixel_color_q;
  assign in_ramwr    = in_ramwr_q;

endmodule

// File: tb/tb_tft_spi_monitor.sv
// Scoreboard bench for tft_spi_monitor: drives SPI traffic, queues the expected
// bytes and pixels, and a monitor compares them as the DUT reports them.
module tb_tft_spi_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        tft_clk, tft_mosi, tft_dc, tft_cs;
  logic        byte_valid, byte_dc, pixel_valid, in_ramwr;
  logic [7:0]  byte_data;
  logic [8:0]  pixel_x, pixel_y;
  logic [15:0] pixel_color;

  int checks = 0;
  int errors = 0;

  logic [8:0]  exp_byte_q[$];
  logic [33:0] exp_pix_q[$];

  tft_spi_monitor dut (
    .clk(clk), .rst(rst), .tft_clk(tft_clk), .tft_mosi(tft_mosi),
    .tft_dc(tft_dc), .tft_cs(tft_cs), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_dc(byte_dc), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color),
    .in_ramwr(in_ramwr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Serial bits MSB first; tft_clk runs at 1/8 of clk
  task automatic applyStimulus(input logic [7:0] b, input logic d, input int nbits);
    tft_cs = 1'b0;
    tft_dc = d;
    for (int i = 0; i < nbits; i++) begin
      tft_mosi = b[7-i];
      #40 tft_clk = 1'b1;
      #40 tft_clk = 1'b0;
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic d);
    exp_byte_q.push_back({d, b});
    applyStimulus(b, d, 8);
  endtask

  task automatic expectPixel(input logic [8:0] x, input logic [8:0] y, input logic [15:0] c);
    exp_pix_q.push_back({x, y, c});
  endtask

  always @(negedge clk) begin
    if (rst && byte_valid) begin
      if (exp_byte_q.size() == 0) checkOutput("unexpected_byte", {25'd0, byte_dc, byte_data}, 34'h3_FFFF_FFFF);
      else checkOutput("byte", {25'd0, byte_dc, byte_data}, {25'd0, exp_byte_q.pop_front()});
    end
    if (rst && pixel_valid) begin
      if (exp_pix_q.size() == 0) checkOutput("unexpected_pixel", {pixel_x, pixel_y, pixel_color}, 34'h3_FFFF_FFFF);
      else checkOutput("pixel", {pixel_x, pixel_y, pixel_color}, exp_pix_q.pop_front());
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_byte_valid"}, {33'd0, byte_valid}, 34'd0);
    checkOutput({tag, "_pixel_valid"}, {33'd0, pixel_valid}, 34'd0);
    checkOutput({tag, "_byte"}, {25'd0, byte_dc, byte_data}, 34'd0);
    checkOutput({tag, "_pixel"}, {pixel_x, pixel_y, pixel_color}, 34'd0);
    checkOutput({tag, "_in_ramwr"}, {33'd0, in_ramwr}, 34'd0);
  endtask

  initial begin
    rst = 1'b0; tft_clk = 1'b0; tft_mosi = 1'b0; tft_dc = 1'b0; tft_cs = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b1;
    #100;

    // Single red pixel at origin
    sendByte(8'h2C, 1'b0);
    expectPixel(9'd0, 9'd0, 16'hF800);
    sendByte(8'hF8, 1'b1);
    sendByte(8'h00, 1'b1);
    #200;
    checkOutput("ramwr_after_pixel", {33'd0, in_ramwr}, 34'd1);

    // 3x2 window, eight pixels wrap back to its origin
    sendByte(8'h2A, 1'b0);
    sendByte(8'h00, 1'b1); sendByte(8'h05, 1'b1);
    sendByte(8'h00, 1'b1); sendByte(8'h07, 1'b1);
    sendByte(8'h2B, 1'b0);
    sendByte(8'h00, 1'b1); sendByte(8'h0A, 1'b1);
    sendByte(8'h00, 1'b1); sendByte(8'h0B, 1'b1);
    #200;
    checkOutput("ramwr_after_paset", {33'd0, in_ramwr}, 34'd0);
    sendByte(8'h2C, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [8:0] ex, ey;
      logic [7:0] hb, lb;
      ex = 9'd5 + 9'(i % 3);
      ey = ((i % 6) < 3) ? 9'd10 : 9'd11;
      hb = 8'h40 + 8'(i);
      lb = 8'hA0 + 8'(i);
      expectPixel(ex, ey, {hb, lb});
      sendByte(hb, 1'b1);
      sendByte(lb, 1'b1);
    end

    // Odd data byte dropped by a following command
    sendByte(8'h2C, 1'b0);
    sendByte(8'h12, 1'b1);
    sendByte(8'h00, 1'b0);
    #200;
    checkOutput("ramwr_after_abort", {33'd0, in_ramwr}, 34'd0);

    // Partial byte discarded on deselect
    applyStimulus(8'hFF, 1'b1, 5);
    tft_cs = 1'b1;
    #100;
    sendByte(8'hA5, 1'b1);
    #200;
    checkOutput("byte_after_cs_abort", {25'd0, byte_dc, byte_data}, {25'd0, 9'h1A5});

    // Column high byte uses only bit 0: 0xFF,0x3F -> 319
    sendByte(8'h2A, 1'b0);
    sendByte(8'hFF, 1'b1); sendByte(8'h3F, 1'b1);
    sendByte(8'hFF, 1'b1); sendByte(8'hFF, 1'b1);
    sendByte(8'h2C, 1'b0);
    expectPixel(9'd319, 9'd10, 16'h1234);
    sendByte(8'h12, 1'b1); sendByte(8'h34, 1'b1);
    expectPixel(9'd320, 9'd10, 16'h5678);
    sendByte(8'h56, 1'b1); sendByte(8'h78, 1'b1);
    #200;

    // Reset during the 4th bit, then a clean byte
    applyStimulus(8'hE0, 1'b1, 3);
    tft_mosi = 1'b1;
    #20;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkResetOutputs("midbyte_reset");
    rst = 1'b1;
    #100;
    sendByte(8'h3C, 1'b1);
    #200;
    checkOutput("byte_after_reset", {25'd0, byte_dc, byte_data}, {25'd0, 9'h13C});
    checkOutput("ramwr_after_reset", {33'd0, in_ramwr}, 34'd0);

    checkOutput("byte_queue_drained", 34'(exp_byte_q.size()), 34'd0);
    checkOutput("pixel_queue_drained", 34'(exp_pix_q.size()), 34'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tft_spi_monitor.md
TFT_SPI_MONITOR -- requirements
Module: tft_spi_monitor

Interface
REQ-001 Parameter X_MAX, default 319, reset-default column end address.
REQ-002 Parameter Y_MAX, default 479, reset-default page end address.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 tft_clk  in  1  SPI clock from the panel transmitter, asynchronous to clk, idle low.
REQ-006 tft_mosi  in  1  serial data, MSB first, stable at tft_clk rising edge.
REQ-007 tft_dc  in  1  0 = command byte, 1 = data byte; stable during the byte.
REQ-008 tft_cs  in  1  chip select, active-low.
REQ-009 byte_valid  out  1  one-cycle pulse, byte received.
REQ-010 byte_data  out  8  last received byte.
REQ-011 byte_dc  out  1  tft_dc value sampled with bit 0 of the last byte.
REQ-012 pixel_valid  out  1  one-cycle pulse, pixel written.
REQ-013 pixel_x  out  9  column of the written pixel.
REQ-014 pixel_y  out  9  row of the written pixel.
REQ-015 pixel_color  out  16  RGB565 value, first data byte in [15:8].
REQ-016 in_ramwr  out  1  high while in memory-write mode.

Function
REQ-017 tft_clk, tft_mosi, tft_dc, tft_cs each pass a 2-flop synchronizer; a tft_clk rising edge is detected from the synchronized value and its one-cycle-delayed copy.
REQ-018 Correct capture is required only for clk at least 4x the tft_clk frequency.
REQ-019 On each detected edge with synchronized cs low: shift synchronized mosi into an 8-bit shift register, increment a 3-bit bit counter.
REQ-020 Synchronized cs high clears the bit counter and discards a partial byte; bytes already decoded are kept.
REQ-021 On the 8th edge: counter wraps to 0; byte_data, byte_dc updated and byte_valid pulses in the next cycle, i.e. 4 clk after the raw 8th tft_clk edge.
REQ-022 Decoder FSM states: IDLE, CASET, PASET, RAMWR; a parameter index 0..3 in CASET/PASET; a high-byte flag in RAMWR.
REQ-023 Any command byte (dc=0) resets parameter index and high-byte flag, then transitions: 0x2A->CASET, 0x2B->PASET, 0x2C->RAMWR, other->IDLE.
REQ-024 RAMWR entry loads current position to (xs, ys).
REQ-025 CASET data bytes 0..3 load xs[8], xs[7:0], xe[8], xe[7:0]; bits above bit 0 of the hi bytes are ignored; after byte 3 go to IDLE.
REQ-026 PASET identical, loading ys, ye.
REQ-027 Data bytes in IDLE are ignored.
REQ-028 In RAMWR, first data byte latched as colour high; second completes a pixel.
REQ-029 Completed pixel: pixel_valid pulses one cycle after the completing byte_valid, with pixel_x/pixel_y = current position.
REQ-030 After each pixel: if x >= xe then x <= xs and y <= (y >= ye) ? ys : y+1; else x <= x+1.
REQ-031 An odd data byte left pending when a command arrives is discarded, no pixel emitted.
REQ-032 Outputs pixel_x, pixel_y, pixel_color, byte_data hold their values between pulses.
REQ-033 in_ramwr = (state == RAMWR), registered.

Reset
REQ-034 rst low at a clk edge: byte_valid=0, pixel_valid=0, byte_data=0, byte_dc=0, pixel_x=0, pixel_y=0, pixel_color=0, in_ramwr=0.
REQ-035 Reset internal state: state IDLE, bit counter 0, xs=0, xe=X_MAX, ys=0, ye=Y_MAX, position (0,0), synchronizers 0.
REQ-036 Reset mid-byte or mid-pixel discards partial data; the first byte after release begins at bit 7.

Verification
REQ-037 Command 0x2C, data 0xF8,0x00 -> one byte_valid with byte_dc=0, 0x2C; pixel_valid at (0,0), colour 0xF800; in_ramwr=1.
REQ-038 CASET 0x00,0x05,0x00,0x07; PASET 0x00,0x0A,0x00,0x0B; RAMWR; 8 pixels -> coordinates (5,10),(6,10),(7,10),(5,11),(6,11),(7,11),(5,10),(6,10).
REQ-039 RAMWR, data 0x12, then command 0x00 -> no pixel_valid; state IDLE; in_ramwr=0.
REQ-040 tft_cs raised after 5 bits, then full byte 0xA5 (dc=1) -> byte_data=0xA5; no corrupted byte.
REQ-041 CASET with hi byte 0xFF, lo 0x3F -> xs=0x13F (319) after the pair.
REQ-042 rst asserted during the 4th bit of a byte -> all outputs 0 next cycle; next full byte 0x3C decoded correctly.
